// File: rtl/order_pkg.sv
// Shared types and default widths for the order gate slice.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package order_pkg;

  localparam int DEF_PRICE_W = 8;
  localparam int DEF_QTY_W   = 8;
  localparam int DEF_POS_W   = 16;

  typedef enum logic {
    SIDE_BUY  = 1'b0,
    SIDE_SELL = 1'b1
  } side_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    COOLDOWN = 2'd2
  } og_state_e;

  typedef logic [DEF_PRICE_W-1:0]      price_t;
  typedef logic [DEF_QTY_W-1:0]        qty_t;
  typedef logic signed [DEF_POS_W-1:0] pos_t;

endpackage

// File: rtl/order_gate_token_bucket.sv
// Token bucket: free-running refill counter adds one token every REFILL_CYC cycles.
// Latency: consume/refill take effect on the next clk edge.
// Backpressure: none; caller must only consume when tokens_avail is high.
// Ports: clk, reset (async, active-high), consume (take one token),
//        tokens_avail (bucket non-empty), tokens (current fill level).
module token_bucket #(
  parameter int TOKENS_MAX = 4,
  parameter int REFILL_CYC = 64,
  localparam int TOK_W     = $clog2(TOKENS_MAX + 1),
  localparam int CNT_W     = $clog2(REFILL_CYC + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             consume,
  output logic             tokens_avail,
  output logic [TOK_W-1:0] tokens
);

  logic [CNT_W-1:0] refill_cnt;
  logic             refill;

  assign refill       = (refill_cnt == CNT_W'(REFILL_CYC - 1));
  assign tokens_avail = (tokens != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refill_cnt <= '0;
      tokens     <= TOK_W'(TOKENS_MAX);
    end else begin
      refill_cnt <= refill ? '0 : refill_cnt + 1'b1;
      // A refill and a consume in the same cycle cancel out.
      if (refill && !consume) begin
        if (tokens != TOK_W'(TOKENS_MAX)) tokens <= tokens + 1'b1;
      end else if (consume && !refill) begin
        tokens <= tokens - 1'b1;
      end
    end
  end

endmodule

// File: rtl/order_gate.sv
// Order gate: turns buy/sell level edges into rate/position-limited priced orders.
// Latency: order valid one cycle after the request edge; fills update position next edge.
// Backpressure: order held stable while ord_ready is low; new requests dropped while busy.
// Ports: clk, reset (async, active-high); buy_order/sell_order levels with bid/ask prices;
//        ord_valid/ord_ready handshake with ord_side/ord_price/ord_qty payload;
//        fill_valid/fill_side/fill_qty fill reports; position (signed), pos_err (sticky).
// Option: define ORDER_GATE_REJECT_CNT_EN to add the rej_cnt dropped-request counter output.
module order_gate
  import order_pkg::*;
#(
  parameter int PRICE_W    = DEF_PRICE_W,
  parameter int QTY_W      = DEF_QTY_W,
  parameter int POS_W      = DEF_POS_W,
  parameter int ORDER_QTY  = 1,
  parameter int POS_LIMIT  = 100,
  parameter int TOKENS_MAX = 4,
  parameter int REFILL_CYC = 64,
  parameter int MIN_GAP    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               buy_order,
  input  logic               sell_order,
  input  logic [PRICE_W-1:0] bid_price,
  input  logic [PRICE_W-1:0] ask_price,
  output logic               ord_valid,
  input  logic               ord_ready,
  output logic               ord_side,
  output logic [PRICE_W-1:0] ord_price,
  output logic [QTY_W-1:0]   ord_qty,
  input  logic               fill_valid,
  input  logic               fill_side,
  input  logic [QTY_W-1:0]   fill_qty,
  output logic [POS_W-1:0]   position,
  output logic               pos_err
`ifdef ORDER_GATE_REJECT_CNT_EN
  ,
  output logic [15:0]        rej_cnt
`endif
);

  localparam int GAP_W = $clog2(MIN_GAP + 1);
  localparam int TOK_W = $clog2(TOKENS_MAX + 1);

  // One extra bit so limit checks and fill sums cannot wrap before saturation.
  typedef logic signed [POS_W:0] wide_t;
  localparam wide_t LIM_P   = wide_t'(POS_LIMIT);
  localparam wide_t LIM_N   = -LIM_P;
  localparam wide_t ORD_Q   = wide_t'(ORDER_QTY);
  localparam wide_t POS_MAX = wide_t'((2 ** (POS_W - 1)) - 1);
  localparam wide_t POS_MIN = -POS_MAX - wide_t'(1);

  og_state_e        state, state_nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic             buy_q, sell_q;
  logic             buy_rise, sell_rise, request, any_rise, accept, limit_ok;
  side_e            req_side;
  logic             tokens_avail;
  logic [TOK_W-1:0] tokens;
  wide_t            pos_ext, pend_buy, pend_sell, fill_ext, pos_sum;

  token_bucket #(
    .TOKENS_MAX(TOKENS_MAX),
    .REFILL_CYC(REFILL_CYC)
  ) u_bucket (
    .clk         (clk),
    .reset       (reset),
    .consume     (accept),
    .tokens_avail(tokens_avail),
    .tokens      (tokens)
  );

  assign buy_rise  = buy_order & ~buy_q;
  assign sell_rise = sell_order & ~sell_q;
  assign any_rise  = buy_rise | sell_rise;
  // Simultaneous edges are ambiguous and count as no request.
  assign request   = buy_rise ^ sell_rise;
  assign req_side  = sell_rise ? SIDE_SELL : SIDE_BUY;

  assign pos_ext   = wide_t'($signed(position));
  assign pend_buy  = (state == HOLD && ord_side == SIDE_BUY)  ? ORD_Q : '0;
  assign pend_sell = (state == HOLD && ord_side == SIDE_SELL) ? ORD_Q : '0;
  assign limit_ok  = (req_side == SIDE_BUY) ? ((pos_ext + pend_buy + ORD_Q) <= LIM_P)
                                            : ((pos_ext - pend_sell - ORD_Q) >= LIM_N);
  assign accept    = (state == IDLE) && request && tokens_avail && (tokens != '0) && limit_ok;

  assign ord_valid = (state == HOLD);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = HOLD;
      HOLD:     if (ord_ready) state_nxt = COOLDOWN;
      COOLDOWN: if (gap_cnt == GAP_W'(MIN_GAP - 1)) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      buy_q     <= 1'b0;
      sell_q    <= 1'b0;
      ord_side  <= 1'b0;
      ord_price <= '0;
      ord_qty   <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= (state == COOLDOWN) ? gap_cnt + 1'b1 : '0;
      buy_q   <= buy_order;
      sell_q  <= sell_order;
      if (accept) begin
        ord_side  <= req_side;
        ord_price <= (req_side == SIDE_SELL) ? ask_price : bid_price;
        ord_qty   <= QTY_W'(ORDER_QTY);
      end
    end
  end

  assign fill_ext = wide_t'({1'b0, fill_qty});
  assign pos_sum  = fill_side ? (pos_ext - fill_ext) : (pos_ext + fill_ext);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      position <= '0;
      pos_err  <= 1'b0;
    end else if (fill_valid) begin
      if (pos_sum > POS_MAX) begin
        position <= POS_MAX[POS_W-1:0];
        pos_err  <= 1'b1;
      end else if (pos_sum < POS_MIN) begin
        position <= POS_MIN[POS_W-1:0];
        pos_err  <= 1'b1;
      end else begin
        position <= pos_sum[POS_W-1:0];
      end
    end
  end

`ifdef ORDER_GATE_REJECT_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rej_cnt <= '0;
    end else if (any_rise && !accept && rej_cnt != 16'hFFFF) begin
      rej_cnt <= rej_cnt + 16'd1;
    end
  end
`else
  logic unused_rise;
  assign unused_rise = any_rise;
`endif

endmodule

// File: tb/tb_order_gate.sv
// Self-checking bench for order_gate: directed scenarios plus a random phase,
// each cycle compared against an abstract cycle model of the gate's rules.
module tb_order_gate;

  localparam int MIN_GAP    = 8;
  localparam int REFILL_CYC = 64;
  localparam int TOKENS_MAX = 4;
  localparam int POS_LIMIT  = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       buy_order, sell_order;
  logic [7:0] bid_price, ask_price;
  logic       ord_valid, ord_ready, ord_side;
  logic [7:0] ord_price, ord_qty;
  logic       fill_valid, fill_side;
  logic [7:0] fill_qty;
  logic [15:0] position;
  logic       pos_err;
`ifdef ORDER_GATE_REJECT_CNT_EN
  logic [15:0] rej_cnt;
`endif

  order_gate dut (
    .clk       (clk),
    .reset     (reset),
    .buy_order (buy_order),
    .sell_order(sell_order),
    .bid_price (bid_price),
    .ask_price (ask_price),
    .ord_valid (ord_valid),
    .ord_ready (ord_ready),
    .ord_side  (ord_side),
    .ord_price (ord_price),
    .ord_qty   (ord_qty),
    .fill_valid(fill_valid),
    .fill_side (fill_side),
    .fill_qty  (fill_qty),
    .position  (position),
    .pos_err   (pos_err)
`ifdef ORDER_GATE_REJECT_CNT_EN
    ,
    .rej_cnt   (rej_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int hs_obs   = 0;

  // Reference model: an order is either outstanding, cooling down, or absent.
  int m_pos, m_tok, m_cool, m_edges, m_rej, m_price;
  bit m_err, m_pend, m_side, m_pb, m_ps;

  always @(posedge clk or posedge reset) begin : model
    bit rb, rs, idle, consume, refill, nside;
    int p, nprice;
    if (reset) begin
      m_pos = 0; m_tok = TOKENS_MAX; m_cool = 0; m_edges = 0; m_rej = 0;
      m_price = 0; m_err = 0; m_pend = 0; m_side = 0; m_pb = 0; m_ps = 0;
    end else begin
      rb = buy_order && !m_pb;
      rs = sell_order && !m_ps;
      idle = !m_pend && (m_cool == 0);
      consume = 0; nside = 0; nprice = 0;
      if (rb || rs) begin
        if (rb && rs)            m_rej++;
        else if (!idle)          m_rej++;
        else if (m_tok == 0)     m_rej++;
        else if (rb ? (m_pos + 1 > POS_LIMIT) : (m_pos - 1 < -POS_LIMIT)) m_rej++;
        else begin
          consume = 1; nside = rs; nprice = rs ? int'(ask_price) : int'(bid_price);
        end
      end
      if (m_pend && ord_ready) begin
        m_pend = 0; m_cool = MIN_GAP;
      end else if (m_cool > 0) begin
        m_cool--;
      end
      if (consume) begin
        m_pend = 1; m_side = nside; m_price = nprice;
      end
      refill = ((m_edges + 1) % REFILL_CYC) == 0;
      m_edges++;
      if (refill && !consume)      m_tok = (m_tok < TOKENS_MAX) ? m_tok + 1 : TOKENS_MAX;
      else if (consume && !refill) m_tok--;
      if (fill_valid) begin
        p = fill_side ? m_pos - int'(fill_qty) : m_pos + int'(fill_qty);
        if (p > 32767)  begin p = 32767;  m_err = 1; end
        if (p < -32768) begin p = -32768; m_err = 1; end
        m_pos = p;
      end
      if (m_rej > 65535) m_rej = 65535;
      m_pb = buy_order; m_ps = sell_order;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and compare every output with the model.
  task automatic step();
    @(negedge clk);
    chk("ord_valid", 32'(ord_valid), 32'(m_pend));
    if (m_pend) begin
      chk("ord_side", 32'(ord_side), 32'(m_side));
      chk("ord_price", 32'(ord_price), m_price);
      chk("ord_qty", 32'(ord_qty), 32'd1);
    end
    chk("position", 32'($signed(position)), m_pos);
    chk("pos_err", 32'(pos_err), 32'(m_err));
    chk("tokens", 32'(dut.u_bucket.tokens), m_tok);
`ifdef ORDER_GATE_REJECT_CNT_EN
    chk("rej_cnt", 32'(rej_cnt), m_rej);
`endif
    if (ord_valid && ord_ready) hs_obs++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    buy_order = 0; sell_order = 0; fill_valid = 0;
    @(negedge clk);
    reset = 1'b0;
    hs_obs = 0;
  endtask

  task automatic buy_pulse(input int gap);
    buy_order = 1'b1;
    step();
    buy_order = 1'b0;
    repeat (gap - 1) step();
  endtask

  task automatic fill(input bit side, input int qty);
    fill_valid = 1'b1; fill_side = side; fill_qty = 8'(qty);
    step();
    fill_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    buy_order = 0; sell_order = 0; bid_price = 0; ask_price = 0;
    ord_ready = 0; fill_valid = 0; fill_side = 0; fill_qty = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    step();
    chk("rst_valid", 32'(ord_valid), 0);
    chk("rst_price", 32'(ord_price), 0);
    chk("rst_pos", 32'(position), 0);
    chk("rst_tok", 32'(dut.u_bucket.tokens), TOKENS_MAX);

    // 1: basic buy, then re-arm only after the cooldown
    bid_price = 8'h70; ask_price = 8'h90; ord_ready = 1; buy_order = 1;
    step();
    chk("t1_valid", 32'(ord_valid), 1);
    chk("t1_side", 32'(ord_side), 0);
    chk("t1_price", 32'(ord_price), 32'h70);
    chk("t1_qty", 32'(ord_qty), 1);
    buy_order = 0;
    repeat (MIN_GAP) step();
    buy_order = 1;
    step();
    chk("t1_cool_drop", 32'(ord_valid), 0);
    buy_order = 0;
    step();
    // 2: backpressure holds the payload; changes and new edges are ignored
    bid_price = 8'(32'h40 + $urandom_range(0, 63));
    buy_order = 1; ord_ready = 0;
    step();
    chk("t1_rearm", 32'(ord_valid), 1);
    buy_order = 0;
    for (int i = 0; i < 5; i++) begin
      bid_price = 8'($urandom); ask_price = 8'($urandom);
      sell_order = (i == 2);
      step();
      chk("t2_hold_valid", 32'(ord_valid), 1);
      chk("t2_hold_side", 32'(ord_side), 0);
    end
    sell_order = 0; ord_ready = 1;
    repeat (MIN_GAP + 2) step();

    // 3: bucket empties after four orders, refill allows one more
    do_reset();
    step();
    for (int i = 0; i < 5; i++) begin
      bid_price = 8'($urandom);
      buy_pulse(MIN_GAP + 3);
    end
    chk("t3_issued4", 32'(hs_obs), 4);
    repeat (12) step();
    buy_pulse(MIN_GAP + 3);
    chk("t3_refill", 32'(hs_obs), 5);

    // 4: position limit including the pending order
    do_reset();
    ord_ready = 0;
    fill(0, 99);
    chk("t4_pos99", 32'($signed(position)), 99);
    buy_order = 1; step();
    chk("t4_issue", 32'(ord_valid), 1);
    buy_order = 0; step();
    buy_order = 1; step();
    buy_order = 0; ord_ready = 1;
    repeat (MIN_GAP + 2) step();
    fill(0, 1);
    buy_order = 1; step();
    chk("t4_limit_buy", 32'(ord_valid), 0);
    buy_order = 0;
    fill(1, 200);
    sell_order = 1; step();
    chk("t4_limit_sell", 32'(ord_valid), 0);
    sell_order = 0;
    fill(0, 1);
    ask_price = 8'($urandom);
    sell_order = 1; step();
    chk("t4_sell_ok", 32'(ord_valid), 1);
    sell_order = 0;
    repeat (MIN_GAP + 2) step();

    // random phase
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) buy_order = ~buy_order;
      if ($urandom_range(0, 5) == 0) sell_order = ~sell_order;
      bid_price = 8'($urandom); ask_price = 8'($urandom);
      ord_ready = ($urandom_range(0, 2) != 0);
      fill_valid = ($urandom_range(0, 3) == 0);
      fill_side = 1'($urandom); fill_qty = 8'($urandom_range(0, 40));
      step();
    end
    buy_order = 0; sell_order = 0; fill_valid = 0; ord_ready = 1;
    repeat (MIN_GAP + 4) step();

    // 5: simultaneous edges are dropped without touching the bucket
    buy_order = 1; sell_order = 1; step();
    chk("t5_conflict", 32'(ord_valid), 0);
    buy_order = 0; sell_order = 0; step();

    // 6: async reset while holding, then positive saturation
    do_reset();
    ord_ready = 0; buy_order = 1; step();
    chk("t6_hold", 32'(ord_valid), 1);
    buy_order = 0;
    #2 reset = 1'b1;
    #1;
    chk("t6_async_valid", 32'(ord_valid), 0);
    chk("t6_rst_pos", 32'(position), 0);
    chk("t6_rst_tok", 32'(dut.u_bucket.tokens), TOKENS_MAX);
    @(negedge clk);
    reset = 1'b0;
    fill_valid = 1; fill_side = 0; fill_qty = 8'hFF;
    repeat (130) step();
    fill_valid = 0;
    step();
    chk("t6_sat_pos", 32'($signed(position)), 32767);
    chk("t6_sat_err", 32'(pos_err), 1);
    fill(1, 10);
    step();
    chk("t6_sticky", 32'(pos_err), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
